// File: rtl/slow_interp.sv
// Slow-playback sample interpolator: one input sample per N output ticks,
// held or linearly interpolated, with a sequential restoring divider.
module slow_interp #(
  parameter int DW         = 16,
  parameter int FW         = 4,
  parameter int MAX_FACTOR = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_pause,
  input  logic          i_mode,
  input  logic [FW-1:0] i_factor,
  input  logic          i_tick,
  input  logic [DW-1:0] i_data,
  input  logic          i_data_valid,
  output logic          o_data_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_underrun,
  output logic          o_tick_drop
);

  localparam int PW = DW + FW + 1;
  localparam int CW = $clog2(PW + 1);
  localparam logic [FW-1:0] NMAX = FW'(MAX_FACTOR);
  localparam logic [FW-1:0] ONE  = FW'(1);
  localparam logic [CW-1:0] CLAST = CW'(PW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DIV,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] d1, d2, buf_q;
  logic          buf_full;
  logic [FW-1:0] k, n_lat;
  logic          mode_lat;
  logic [FW-1:0] rem;
  logic [PW-1:0] quo;
  logic          neg;
  logic [CW-1:0] cnt;

  logic [FW-1:0] n_eff, kk;
  logic [DW:0]   diff;
  logic [PW-1:0] diff_x, prod, mag, q_s;
  logic [FW:0]   trial, rem_nx;
  logic          ge;
  logic          tick_go, consume, accept;

  assign o_data_ready = ~buf_full;

  // Effective slow factor, operand preparation and one divider step
  always_comb begin
    n_eff = i_factor;
    if (i_factor <= ONE) n_eff = ONE;
    else if (i_factor > NMAX) n_eff = NMAX;
    kk     = mode_lat ? k : '0;
    diff   = {d2[DW-1], d2} - {d1[DW-1], d1};
    diff_x = {{FW{diff[DW]}}, diff};
    prod   = diff_x * {{(PW-FW){1'b0}}, kk};
    mag    = prod[PW-1] ? (~prod + 1'b1) : prod;
    trial  = {rem, quo[PW-1]};
    ge     = trial >= {1'b0, n_lat};
    rem_nx = ge ? (trial - {1'b0, n_lat}) : trial;
    q_s    = neg ? (~quo + 1'b1) : quo;
  end

  assign tick_go = i_tick & ~i_pause;
  assign consume = (state == IDLE) & tick_go & (k == '0) & buf_full;
  assign accept  = i_data_valid & ~buf_full & ~i_start;

  // Sequencer, history, input buffer and divider datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      d1          <= '0;
      d2          <= '0;
      buf_q       <= '0;
      buf_full    <= 1'b0;
      k           <= '0;
      n_lat       <= ONE;
      mode_lat    <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_underrun  <= 1'b0;
      o_tick_drop <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_underrun  <= 1'b0;
      o_tick_drop <= 1'b0;
      if (i_start) begin
        state    <= IDLE;
        d1       <= '0;
        d2       <= '0;
        buf_full <= 1'b0;
        k        <= '0;
        rem      <= '0;
        quo      <= '0;
        cnt      <= '0;
        o_data   <= '0;
      end else begin
        buf_full <= accept | (buf_full & ~consume);
        if (accept) buf_q <= i_data;
        if (tick_go && state != IDLE) o_tick_drop <= 1'b1;
        unique case (state)
          IDLE: begin
            if (tick_go) begin
              if (k != '0) begin
                state <= SETUP;
              end else if (buf_full) begin
                d1       <= d2;
                d2       <= buf_q;
                n_lat    <= n_eff;
                mode_lat <= i_mode;
                state    <= SETUP;
              end else begin
                o_underrun <= 1'b1;
              end
            end
          end
          SETUP: begin
            quo   <= mag;
            neg   <= prod[PW-1];
            rem   <= '0;
            cnt   <= CLAST;
            state <= DIV;
          end
          DIV: begin
            rem <= rem_nx[FW-1:0];
            quo <= {quo[PW-2:0], ge};
            if (cnt == '0) state <= DONE;
            else cnt <= cnt - 1'b1;
          end
          DONE: begin
            o_data  <= d1 + q_s[DW-1:0];
            o_valid <= 1'b1;
            k       <= (k == n_lat - ONE) ? '0 : k + ONE;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slow_interp.sv
// Directed testbench for slow_interp: vector table of per-tick
// expectations plus hand sequences for drop, underrun and abort.
module tb_slow_interp;

  localparam int LAT = 23;

  logic        i_clk, i_rst_n, i_start, i_pause, i_mode;
  logic [3:0]  i_factor;
  logic        i_tick, i_data_valid;
  logic [15:0] i_data;
  logic        o_data_ready, o_valid, o_underrun, o_tick_drop;
  logic [15:0] o_data;

  int n_chk = 0;
  int n_fail = 0;

  slow_interp dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_pause(i_pause), .i_mode(i_mode), .i_factor(i_factor),
    .i_tick(i_tick), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_data(o_data), .o_valid(o_valid),
    .o_underrun(o_underrun), .o_tick_drop(o_tick_drop)
  );

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    bit                 clr;
    bit                 mode;
    logic [3:0]         fac;
    bit                 push;
    logic signed [15:0] din;
    logic signed [15:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit c, bit m, int f, bit p, int d, int e);
    vec_t v;
    v.clr = c; v.mode = m; v.fac = 4'(f);
    v.push = p; v.din = 16'(d); v.exp = 16'(e);
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_start();
    @(posedge i_clk); #1 i_start = 1;
    @(posedge i_clk); #1 i_start = 0;
  endtask

  task automatic do_push(input logic [15:0] d);
    int w;
    w = 0;
    while (!o_data_ready && w < 50) begin
      @(posedge i_clk); #1 w++;
    end
    chk("push_ready", int'(o_data_ready), 1);
    i_data_valid = 1; i_data = d;
    @(posedge i_clk); #1 i_data_valid = 0;
  endtask

  task automatic do_tick(output int lat, output bit ur);
    lat = -1;
    @(posedge i_clk); #1 i_tick = 1;
    @(posedge i_clk); #1 i_tick = 0;
    ur = o_underrun;
    for (int i = 1; i <= 40; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit ur;
    i_rst_n = 0; i_start = 0; i_pause = 0; i_mode = 0;
    i_factor = 0; i_tick = 0; i_data = 0; i_data_valid = 0;

    tv.push_back(mk(1, 1, 4, 1, 100, 0));
    tv.push_back(mk(0, 1, 4, 1, 500, 25));
    tv.push_back(mk(0, 1, 4, 0, 0, 50));
    tv.push_back(mk(0, 1, 4, 0, 0, 75));
    tv.push_back(mk(0, 1, 4, 0, 0, 100));
    tv.push_back(mk(0, 1, 4, 0, 0, 200));
    tv.push_back(mk(0, 1, 4, 0, 0, 300));
    tv.push_back(mk(0, 1, 4, 0, 0, 400));
    tv.push_back(mk(1, 1, 3, 1, -7, 0));
    tv.push_back(mk(0, 1, 3, 0, 0, -2));
    tv.push_back(mk(0, 1, 3, 0, 0, -4));
    tv.push_back(mk(1, 0, 3, 1, 100, 0));
    tv.push_back(mk(0, 0, 3, 1, 200, 0));
    tv.push_back(mk(0, 0, 3, 0, 0, 0));
    tv.push_back(mk(0, 0, 3, 0, 0, 100));
    tv.push_back(mk(0, 0, 3, 0, 0, 100));
    tv.push_back(mk(0, 0, 3, 0, 0, 100));
    tv.push_back(mk(1, 1, 0, 1, 10, 0));
    tv.push_back(mk(0, 1, 0, 1, 20, 10));
    tv.push_back(mk(0, 1, 1, 1, 30, 20));
    tv.push_back(mk(1, 1, 15, 1, 800, 0));
    tv.push_back(mk(0, 1, 15, 0, 0, 100));
    tv.push_back(mk(0, 1, 15, 0, 0, 200));

    #12;
    chk("rst_data", int'(o_data), 0);
    chk("rst_ready", int'(o_data_ready), 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_pulses", int'({o_underrun, o_tick_drop}), 0);
    i_rst_n = 1;

    foreach (tv[i]) begin
      if (tv[i].clr) do_start();
      i_mode = tv[i].mode;
      i_factor = tv[i].fac;
      if (tv[i].push) do_push(tv[i].din);
      do_tick(lat, ur);
      chk($sformatf("vec%0d_lat", i), lat, LAT);
      chk($sformatf("vec%0d_data", i),
          int'($signed(o_data)), int'(tv[i].exp));
    end

    // second tick 5 cycles into a compute is dropped, phase unchanged
    do_start();
    i_mode = 1; i_factor = 4;
    do_push(16'd100);
    @(posedge i_clk); #1 i_tick = 1;
    @(posedge i_clk); #1 i_tick = 0;
    repeat (4) @(posedge i_clk);
    #1 i_tick = 1;
    @(posedge i_clk); #1 i_tick = 0;
    chk("drop_pulse", int'(o_tick_drop), 1);
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) begin
        lat = i;
        break;
      end
    end
    chk("drop_lat", lat, LAT);
    chk("drop_data", int'(o_data), 0);
    do_tick(lat, ur);
    chk("drop_next", int'(o_data), 25);

    // empty buffer at segment start
    do_start();
    i_mode = 1; i_factor = 1;
    do_push(16'd10);
    do_tick(lat, ur);
    do_push(16'd20);
    do_tick(lat, ur);
    chk("ur_pre", int'(o_data), 10);
    do_tick(lat, ur);
    chk("ur_pulse", int'(ur), 1);
    chk("ur_novalid", lat, -1);
    chk("ur_hold", int'(o_data), 10);

    // start mid-divide aborts, same-cycle data refused
    do_push(16'd40);
    @(posedge i_clk); #1 i_tick = 1;
    @(posedge i_clk); #1 i_tick = 0;
    repeat (4) @(posedge i_clk);
    #1 i_start = 1; i_data_valid = 1; i_data = 16'd55;
    @(posedge i_clk); #1 i_start = 0; i_data_valid = 0;
    chk("abort_data", int'(o_data), 0);
    chk("abort_ready", int'(o_data_ready), 1);
    ur = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) ur = 1;
    end
    chk("abort_novalid", int'(ur), 0);
    do_tick(lat, ur);
    chk("abort_empty", int'(ur), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
